// File: rtl/nios_led_pio_gpio.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised inputs, edge capture, maskable irq.
// Define PIO_BITSET_EN to add the OUTSET (addr 4) / OUTCLEAR (addr 5) write ports.

module nios_led_pio_gpio_lane #(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  input  logic clr_i,
  output logic sync_o,
  output logic cap_o
);
  logic sync1_q, sync_q, prev_q, cap_q, cap_d, edge_w;

  always_comb begin
    edge_w = 1'b0;
    case (EDGE_TYPE)
      0:       edge_w = sync_q & ~prev_q;
      1:       edge_w = ~sync_q & prev_q;
      default: edge_w = sync_q ^ prev_q;
    endcase
    // A detected edge beats a same-cycle write-1-clear.
    cap_d = (cap_q & ~clr_i) | edge_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
      cap_q   <= cap_d;
    end
  end

  assign sync_o = sync_q;
  assign cap_o  = cap_q;
endmodule

module nios_led_pio_gpio #(
  parameter int                  DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                  EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);
  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_CAP = 3'd3;
`ifdef PIO_BITSET_EN
  localparam logic [2:0] A_SET = 3'd4, A_CLR = 3'd5;
`endif

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d;
  logic [DATA_WIDTH-1:0] in_sync, cap, cap_clr, rd;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  assign cap_clr = (wr && address == A_CAP) ? wd : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_lane
      nios_led_pio_gpio_lane #(.EDGE_TYPE(EDGE_TYPE)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port[gi]),
        .clr_i   (cap_clr[gi]),
        .sync_o  (in_sync[gi]),
        .cap_o   (cap[gi])
      );
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr) begin
      case (address)
        A_DATA: data_d = wd;
        A_DIR:  dir_d  = wd;
        A_MASK: mask_d = wd;
`ifdef PIO_BITSET_EN
        A_SET:  data_d = data_q | wd;
        A_CLR:  data_d = data_q & ~wd;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      A_DATA:  rd = (data_q & dir_q) | (in_sync & ~dir_q);
      A_DIR:   rd = dir_q;
      A_MASK:  rd = mask_q;
      A_CAP:   rd = cap;
      default: rd = '0;
    endcase
    readdata = '0;
    readdata[DATA_WIDTH-1:0] = rd;
  end

  assign out_port = data_q;
  assign out_oe   = dir_q;
  assign irq      = |(cap & mask_q);
endmodule

// File: tb/tb_nios_led_pio_gpio.sv
// Directed self-checking bench for nios_led_pio_gpio (8 bits, reset value A5, rising edge).
module tb_nios_led_pio_gpio;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port, out_oe;
  logic        irq;
  int          n_chk = 0, n_err = 0;

  nios_led_pio_gpio #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_oe(out_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    edges(2);
    chk("rst_out", {24'h0, out_port}, 32'hA5);
    chk("rst_oe", {24'h0, out_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst_rd0", 3'd0, 32'h0);
    rd_chk("rst_rd1", 3'd1, 32'h0);
    rd_chk("rst_rd2", 3'd2, 32'h0);
    rd_chk("rst_rd3", 3'd3, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // All outputs, upper writedata bits ignored
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd0, 32'h1234_56C3);
    chk("out_c3", {24'h0, out_port}, 32'hC3);
    chk("oe_ff", {24'h0, out_oe}, 32'hFF);
    rd_chk("rd0_c3", 3'd0, 32'h0000_00C3);

    // Mixed direction read-back through the synchroniser
    bus_wr(3'd1, 32'h0F);
    bus_wr(3'd0, 32'h0A);
    @(negedge clk) in_port = 8'h50;
    edges(1);
    rd_chk("mix_e1", 3'd0, 32'h0A);
    edges(2);
    rd_chk("mix_e3", 3'd0, 32'h5A);
    edges(1);
    rd_chk("cap_50", 3'd3, 32'h50);
    chk("irq_unmasked", {31'h0, irq}, 32'h0);
    bus_wr(3'd3, 32'hFF);
    rd_chk("cap_clr_all", 3'd3, 32'h0);

    // Masked rising edge on bit 0: irq exactly on the third edge
    bus_wr(3'd2, 32'h01);
    rd_chk("mask_rd", 3'd2, 32'h01);
    @(negedge clk) in_port = 8'h51;
    edges(2);
    chk("irq_e2", {31'h0, irq}, 32'h0);
    edges(1);
    chk("irq_e3", {31'h0, irq}, 32'h1);
    rd_chk("cap_01", 3'd3, 32'h01);
    bus_wr(3'd3, 32'h01);
    rd_chk("cap_w1c", 3'd3, 32'h0);
    chk("irq_w1c", {31'h0, irq}, 32'h0);

    // Write-1-clear coinciding with a new rising edge: set wins
    @(negedge clk) in_port = 8'h50;
    edges(4);
    rd_chk("fall_nocap", 3'd3, 32'h0);
    @(negedge clk) in_port = 8'h51;
    edges(2);
    bus_wr(3'd3, 32'h01);
    rd_chk("set_wins", 3'd3, 32'h01);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);
    bus_wr(3'd3, 32'h01);
    rd_chk("clr_after", 3'd3, 32'h0);

    // Set/clear ports and unmapped addresses
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd0, 32'h0F);
    bus_wr(3'd4, 32'hF0);
`ifdef PIO_BITSET_EN
    chk("outset", {24'h0, out_port}, 32'hFF);
`else
    chk("outset_off", {24'h0, out_port}, 32'h0F);
`endif
    bus_wr(3'd5, 32'h3C);
`ifdef PIO_BITSET_EN
    chk("outclr", {24'h0, out_port}, 32'hC3);
`else
    chk("outclr_off", {24'h0, out_port}, 32'h0F);
`endif
    rd_chk("rd4", 3'd4, 32'h0);
    rd_chk("rd5", 3'd5, 32'h0);
    bus_wr(3'd6, 32'hFF);
    rd_chk("rd6", 3'd6, 32'h0);
    rd_chk("rd7", 3'd7, 32'h0);
    rd_chk("rd1_after6", 3'd1, 32'hFF);

    // Full capture, then asynchronous reset between clock edges
    bus_wr(3'd2, 32'hFF);
    @(negedge clk) in_port = 8'h00;
    edges(4);
    bus_wr(3'd3, 32'hFF);
    @(negedge clk) in_port = 8'hFF;
    edges(4);
    rd_chk("cap_ff", 3'd3, 32'hFF);
    chk("irq_ff", {31'h0, irq}, 32'h1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_out", {24'h0, out_port}, 32'hA5);
    chk("arst_oe", {24'h0, out_oe}, 32'h0);
    rd_chk("arst_cap", 3'd3, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
